vecreg_mp: RTL and testbench
============================

# vecreg_mp

Multi-entry, multi-port vector register file with predicate register bank. Sits between mpu/vpu controllers and the mpu/vpu datapaths and replaces the single-entry register file. Adds full indexed storage, two independent write ports with fixed priority, per-lane predicated writes, registered reads with write-first bypass, and a write-conflict status pulse.

## Interface
- VR_PROC_WTH, 32, bits per lane
- VR_PROC_PARAL, 64, lanes per vector
- VR_IND_WTH, 4, vector register index width (VR_IND_SIZE = 2^VR_IND_WTH entries)
- VPR_IND_WTH, 3, predicate register index width (VPR_IND_SIZE = 2^VPR_IND_WTH entries)
- VR_DATA_WTH, VR_PROC_PARAL*VR_PROC_WTH, vector width
- VPR_DATA_WTH, VR_PROC_PARAL, predicate width (1 bit per lane)
- BYPASS_EN, 1, 1 = write-first read bypass; 0 = read-first

- clk_i  in  1  clock; single clock domain
- rst_n_i  in  1  reset; synchronous, active-low
- mpu_vr__windex_i / mpu_vr__we_i / mpu_vr__wdata_i  in  VR_IND_WTH / 1 / VR_DATA_WTH  mpu write port (full width)
- mpu_vr__rindex_i / mpu_vr__re_i  in  VR_IND_WTH / 1  mpu read request
- mpu_vr__rdata_o / mpu_vr__rdata_act_o  out  VR_DATA_WTH / 1  mpu read data and valid
- vpu_vr__rd_windex_i / vpu_vr__rd_we_i / vpu_vr__rd_wdata_i  in  VR_IND_WTH / 1 / VR_DATA_WTH  vpu write port
- vpu_vr__rd_masked_i  in  1  1 = lane-masked vpu write
- vpu_vr__rd_pindex_i  in  VPR_IND_WTH  predicate register providing the lane mask
- vpu_vr__rs0_rindex_i / vpu_vr__rs1_rindex_i / vpu_vr__rs_re_i  in  VR_IND_WTH x2 / 1  vpu dual read
- vpu_vr__rs0_rdata_o / vpu_vr__rs1_rdata_o / vpu_vr__rs_rdata_act_o  out  VR_DATA_WTH x2 / 1
- vpu_vr__rpd_windex_i / vpu_vr__rpd_we_i / vpu_vr__rpd_wdata_i  in  VPR_IND_WTH / 1 / VPR_DATA_WTH  predicate write
- vpu_vr__rps0_rindex_i / vpu_vr__rps1_rindex_i / vpu_vr__rps_re_i  in  VPR_IND_WTH x2 / 1  predicate dual read
- vpu_vr__rps0_rdata_o / vpu_vr__rps1_rdata_o / vpu_vr__rps_rdata_act_o  out  VPR_DATA_WTH x2 / 1
- vr__wr_conflict_o  out  1  registered pulse: both write ports hit same index in one cycle

## Operation
- Storage: VR_IND_SIZE x VR_DATA_WTH vector entries, VPR_IND_SIZE x VPR_DATA_WTH predicate entries; all cleared to 0 on reset.
- Writes commit at posedge. Different indices on both vector write ports: both commit. Same index: mpu wins entirely, vpu write dropped, vr__wr_conflict_o = 1 next cycle.
- Masked vpu write: lane k (bits [k*VR_PROC_WTH +: VR_PROC_WTH]) updated only if predicate[rd_pindex][k] = 1; unmasked lanes keep old value. Mask uses predicate contents before the current edge (no bypass from same-cycle rpd write). Mask all-zero: no lanes change, not an error. vpu_vr__rd_masked_i = 0: all lanes written.
- Vector dropped by conflict is dropped in all lanes, masked or not.
- Reads: when re high at edge N, index sampled, data registered; outputs hold last value when re low.
- BYPASS_EN = 1: read of an index written at the same edge returns the newly written value (post-mask, post-priority merge). BYPASS_EN = 0: returns old value.
- Same rules apply to predicate reads vs rpd write.
- rs0 and rs1 may address the same entry; both return identical data.

## Timing
- Read latency 1: request at edge N -> data and act valid after edge N, until next edge.
- act outputs = registered copies of corresponding re inputs, 1-cycle pulses per request.
- Write-to-read visibility: read at edge N+1 or later always sees write from edge N; same-edge per BYPASS_EN.
- Reset (rst_n_i low at edge): all entries, all rdata outputs, all act outputs, vr__wr_conflict_o = 0 after that edge; requests during reset ignored; mid-operation reset discards in-flight read (act 0 next cycle).
- No backpressure; one request per port per cycle, sustained throughput 1/cycle/port.

## Test plan
- Reset then read every vector/predicate entry -> all rdata 0, act pulses one cycle after each re.
- mpu writes 0xA5.. to v3, vpu writes 0x5A.. to v7 same cycle; next cycle rs0=v3, rs1=v7 -> both values returned, no conflict.
- Both ports write v5 same cycle (mpu 0x1111.., vpu 0x2222..) -> v5 = 0x1111.., vr__wr_conflict_o pulses 1 cycle.
- p2 = 0x..0F (lanes 0-3); masked vpu write of all-ones to v1 (previously 0) via p2 -> v1 lanes 0-3 all-ones, others 0; repeat with p2 = 0 -> v1 unchanged.
- BYPASS_EN=1: write v9 = X and read v9 same edge -> X next cycle; BYPASS_EN=0 -> old value, X on following read.
- Assert rst_n_i low during back-to-back reads -> act drops to 0, all storage zero after release.

Source files
------------

// File: rtl/vecreg_mp.sv
// Multi-port vector register file with predicate bank: two vector write ports
// (mpu has priority), per-lane predicated vpu writes, registered reads with optional write-first bypass.
module vecreg_mp #(
   parameter int VR_PROC_WTH  = 32,
   parameter int VR_PROC_PARAL = 64,
   parameter int VR_IND_WTH   = 4,
   parameter int VPR_IND_WTH  = 3,
   parameter int VR_DATA_WTH  = VR_PROC_PARAL * VR_PROC_WTH,
   parameter int VPR_DATA_WTH = VR_PROC_PARAL,
   parameter int BYPASS_EN    = 1
) (
   input  logic                    clk_i,
   input  logic                    rst_n_i,
   input  logic [VR_IND_WTH-1:0]   mpu_vr__windex_i,
   input  logic                    mpu_vr__we_i,
   input  logic [VR_DATA_WTH-1:0]  mpu_vr__wdata_i,
   input  logic [VR_IND_WTH-1:0]   mpu_vr__rindex_i,
   input  logic                    mpu_vr__re_i,
   output logic [VR_DATA_WTH-1:0]  mpu_vr__rdata_o,
   output logic                    mpu_vr__rdata_act_o,
   input  logic [VR_IND_WTH-1:0]   vpu_vr__rd_windex_i,
   input  logic                    vpu_vr__rd_we_i,
   input  logic [VR_DATA_WTH-1:0]  vpu_vr__rd_wdata_i,
   input  logic                    vpu_vr__rd_masked_i,
   input  logic [VPR_IND_WTH-1:0]  vpu_vr__rd_pindex_i,
   input  logic [VR_IND_WTH-1:0]   vpu_vr__rs0_rindex_i,
   input  logic [VR_IND_WTH-1:0]   vpu_vr__rs1_rindex_i,
   input  logic                    vpu_vr__rs_re_i,
   output logic [VR_DATA_WTH-1:0]  vpu_vr__rs0_rdata_o,
   output logic [VR_DATA_WTH-1:0]  vpu_vr__rs1_rdata_o,
   output logic                    vpu_vr__rs_rdata_act_o,
   input  logic [VPR_IND_WTH-1:0]  vpu_vr__rpd_windex_i,
   input  logic                    vpu_vr__rpd_we_i,
   input  logic [VPR_DATA_WTH-1:0] vpu_vr__rpd_wdata_i,
   input  logic [VPR_IND_WTH-1:0]  vpu_vr__rps0_rindex_i,
   input  logic [VPR_IND_WTH-1:0]  vpu_vr__rps1_rindex_i,
   input  logic                    vpu_vr__rps_re_i,
   output logic [VPR_DATA_WTH-1:0] vpu_vr__rps0_rdata_o,
   output logic [VPR_DATA_WTH-1:0] vpu_vr__rps1_rdata_o,
   output logic                    vpu_vr__rps_rdata_act_o,
   output logic                    vr__wr_conflict_o
);

   localparam int VR_IND_SIZE  = 1 << VR_IND_WTH;
   localparam int VPR_IND_SIZE = 1 << VPR_IND_WTH;

   logic [VR_DATA_WTH-1:0]  vr_q  [VR_IND_SIZE];
   logic [VR_DATA_WTH-1:0]  vr_d  [VR_IND_SIZE];
   logic [VPR_DATA_WTH-1:0] vpr_q [VPR_IND_SIZE];
   logic [VPR_DATA_WTH-1:0] vpr_d [VPR_IND_SIZE];

   logic [VR_DATA_WTH-1:0]  mpu_rdata_q, mpu_rdata_d;
   logic [VR_DATA_WTH-1:0]  rs0_rdata_q, rs0_rdata_d;
   logic [VR_DATA_WTH-1:0]  rs1_rdata_q, rs1_rdata_d;
   logic [VPR_DATA_WTH-1:0] rps0_rdata_q, rps0_rdata_d;
   logic [VPR_DATA_WTH-1:0] rps1_rdata_q, rps1_rdata_d;
   logic mpu_act_q, mpu_act_d;
   logic rs_act_q, rs_act_d;
   logic rps_act_q, rps_act_d;
   logic wr_conflict_q, wr_conflict_d;

   // Write merge: vpu lanes first, then the mpu overwrites the whole entry so a
   // same-index collision drops the vpu write in every lane.
   // NOTE: combinational next-state uses blocking '=' with every output defaulted
   // first; this keeps the merge order explicit and prevents latch inference.
   always_comb begin
      vr_d  = vr_q;
      vpr_d = vpr_q;
      if (vpu_vr__rd_we_i) begin
         for (int k = 0; k < VR_PROC_PARAL; k++) begin
            if (!vpu_vr__rd_masked_i || vpr_q[vpu_vr__rd_pindex_i][k])
               vr_d[vpu_vr__rd_windex_i][k*VR_PROC_WTH +: VR_PROC_WTH] =
                  vpu_vr__rd_wdata_i[k*VR_PROC_WTH +: VR_PROC_WTH];
         end
      end
      if (mpu_vr__we_i)
         vr_d[mpu_vr__windex_i] = mpu_vr__wdata_i;
      if (vpu_vr__rpd_we_i)
         vpr_d[vpu_vr__rpd_windex_i] = vpu_vr__rpd_wdata_i;
      wr_conflict_d = mpu_vr__we_i && vpu_vr__rd_we_i &&
                      (mpu_vr__windex_i == vpu_vr__rd_windex_i);
   end

   // Read capture: with bypass the source is the post-merge next state.
   always_comb begin
      mpu_rdata_d  = mpu_rdata_q;
      rs0_rdata_d  = rs0_rdata_q;
      rs1_rdata_d  = rs1_rdata_q;
      rps0_rdata_d = rps0_rdata_q;
      rps1_rdata_d = rps1_rdata_q;
      mpu_act_d    = mpu_vr__re_i;
      rs_act_d     = vpu_vr__rs_re_i;
      rps_act_d    = vpu_vr__rps_re_i;
      if (mpu_vr__re_i)
         mpu_rdata_d = (BYPASS_EN != 0) ? vr_d[mpu_vr__rindex_i] : vr_q[mpu_vr__rindex_i];
      if (vpu_vr__rs_re_i) begin
         rs0_rdata_d = (BYPASS_EN != 0) ? vr_d[vpu_vr__rs0_rindex_i] : vr_q[vpu_vr__rs0_rindex_i];
         rs1_rdata_d = (BYPASS_EN != 0) ? vr_d[vpu_vr__rs1_rindex_i] : vr_q[vpu_vr__rs1_rindex_i];
      end
      if (vpu_vr__rps_re_i) begin
         rps0_rdata_d = (BYPASS_EN != 0) ? vpr_d[vpu_vr__rps0_rindex_i] : vpr_q[vpu_vr__rps0_rindex_i];
         rps1_rdata_d = (BYPASS_EN != 0) ? vpr_d[vpu_vr__rps1_rindex_i] : vpr_q[vpu_vr__rps1_rindex_i];
      end
   end

   // NOTE: the storage arrays are reset along with the control flops because the
   // register file must read back as zero after reset; this is why they are flops, not RAM.
   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         vr_q          <= '{default: '0};
         vpr_q         <= '{default: '0};
         mpu_rdata_q   <= '0;
         rs0_rdata_q   <= '0;
         rs1_rdata_q   <= '0;
         rps0_rdata_q  <= '0;
         rps1_rdata_q  <= '0;
         mpu_act_q     <= 1'b0;
         rs_act_q      <= 1'b0;
         rps_act_q     <= 1'b0;
         wr_conflict_q <= 1'b0;
      end else begin
         vr_q          <= vr_d;
         vpr_q         <= vpr_d;
         mpu_rdata_q   <= mpu_rdata_d;
         rs0_rdata_q   <= rs0_rdata_d;
         rs1_rdata_q   <= rs1_rdata_d;
         rps0_rdata_q  <= rps0_rdata_d;
         rps1_rdata_q  <= rps1_rdata_d;
         mpu_act_q     <= mpu_act_d;
         rs_act_q      <= rs_act_d;
         rps_act_q     <= rps_act_d;
         wr_conflict_q <= wr_conflict_d;
      end
   end

   assign mpu_vr__rdata_o         = mpu_rdata_q;
   assign mpu_vr__rdata_act_o     = mpu_act_q;
   assign vpu_vr__rs0_rdata_o     = rs0_rdata_q;
   assign vpu_vr__rs1_rdata_o     = rs1_rdata_q;
   assign vpu_vr__rs_rdata_act_o  = rs_act_q;
   assign vpu_vr__rps0_rdata_o    = rps0_rdata_q;
   assign vpu_vr__rps1_rdata_o    = rps1_rdata_q;
   assign vpu_vr__rps_rdata_act_o = rps_act_q;
   assign vr__wr_conflict_o       = wr_conflict_q;

endmodule

// File: tb/tb_vecreg_mp.sv
// Bench for vecreg_mp: a bypass and a read-first instance share all inputs; a
// reference model pushes expected read data to a scoreboard checked after each edge.
module tb_vecreg_mp;

   localparam int LW = 32;
   localparam int NL = 64;
   localparam int VW = LW * NL;
   localparam int PW = NL;

   logic clk;
   logic rst_n;
   logic [3:0]    mpu_widx, mpu_ridx, vpu_widx, rs0_idx, rs1_idx;
   logic          mpu_we, mpu_re, vpu_we, vpu_masked, rs_re;
   logic [VW-1:0] mpu_wdata, vpu_wdata;
   logic [2:0]    vpu_pidx, rpd_widx, rps0_idx, rps1_idx;
   logic          rpd_we, rps_re;
   logic [PW-1:0] rpd_wdata;

   logic [VW-1:0] vdata [2][3];
   logic [PW-1:0] pdata [2][2];
   logic          act_o [2][3];
   logic          conf_o [2];

   typedef struct {
      int            inst;
      int            sel;
      logic [VW-1:0] d;
   } exp_t;
   exp_t sb [$];

   logic [VW-1:0] vm [16];
   logic [VW-1:0] vm_n [16];
   logic [PW-1:0] pm [8];
   logic [PW-1:0] pm_n [8];

   int n_tests = 0;
   int n_fail  = 0;

   for (genvar b = 0; b < 2; b++) begin : g_dut
      vecreg_mp #(
         .VR_PROC_WTH(LW), .VR_PROC_PARAL(NL), .VR_IND_WTH(4), .VPR_IND_WTH(3),
         .VR_DATA_WTH(VW), .VPR_DATA_WTH(PW), .BYPASS_EN(b)
      ) dut (
         .clk_i(clk), .rst_n_i(rst_n),
         .mpu_vr__windex_i(mpu_widx), .mpu_vr__we_i(mpu_we), .mpu_vr__wdata_i(mpu_wdata),
         .mpu_vr__rindex_i(mpu_ridx), .mpu_vr__re_i(mpu_re),
         .mpu_vr__rdata_o(vdata[b][0]), .mpu_vr__rdata_act_o(act_o[b][0]),
         .vpu_vr__rd_windex_i(vpu_widx), .vpu_vr__rd_we_i(vpu_we), .vpu_vr__rd_wdata_i(vpu_wdata),
         .vpu_vr__rd_masked_i(vpu_masked), .vpu_vr__rd_pindex_i(vpu_pidx),
         .vpu_vr__rs0_rindex_i(rs0_idx), .vpu_vr__rs1_rindex_i(rs1_idx), .vpu_vr__rs_re_i(rs_re),
         .vpu_vr__rs0_rdata_o(vdata[b][1]), .vpu_vr__rs1_rdata_o(vdata[b][2]),
         .vpu_vr__rs_rdata_act_o(act_o[b][1]),
         .vpu_vr__rpd_windex_i(rpd_widx), .vpu_vr__rpd_we_i(rpd_we), .vpu_vr__rpd_wdata_i(rpd_wdata),
         .vpu_vr__rps0_rindex_i(rps0_idx), .vpu_vr__rps1_rindex_i(rps1_idx), .vpu_vr__rps_re_i(rps_re),
         .vpu_vr__rps0_rdata_o(pdata[b][0]), .vpu_vr__rps1_rdata_o(pdata[b][1]),
         .vpu_vr__rps_rdata_act_o(act_o[b][2]),
         .vr__wr_conflict_o(conf_o[b])
      );
   end

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] fold(input logic [VW-1:0] v);
      logic [31:0] f = '0;
      for (int i = 0; i < NL; i++) f ^= v[i*LW +: LW];
      return f;
   endfunction

   function automatic logic [VW-1:0] obs(input int b, input int s);
      case (s)
         0, 1, 2: return vdata[b][s];
         3:       return {{(VW-PW){1'b0}}, pdata[b][0]};
         default: return {{(VW-PW){1'b0}}, pdata[b][1]};
      endcase
   endfunction

   task automatic check(input string tag, input logic [VW-1:0] got, input logic [VW-1:0] exp);
      n_tests++;
      assert (got === exp) else begin
         n_fail++;
         $error("FAIL %s: observed lo=%h hi=%h fold=%h, expected lo=%h hi=%h fold=%h",
                tag, got[63:0], got[VW-1 -: 64], fold(got), exp[63:0], exp[VW-1 -: 64], fold(exp));
      end
   endtask

   task automatic push(input int b, input int s, input logic [VW-1:0] d);
      exp_t e;
      e.inst = b;
      e.sel  = s;
      e.d    = d;
      sb.push_back(e);
   endtask

   task automatic idle();
      mpu_we = 0; mpu_re = 0; vpu_we = 0; vpu_masked = 0; rs_re = 0; rpd_we = 0; rps_re = 0;
   endtask

   function automatic logic [VW-1:0] rnd_vec();
      logic [VW-1:0] v;
      for (int i = 0; i < NL; i++) v[i*LW +: LW] = $urandom;
      return v;
   endfunction

   // One clock: model the edge, queue expected reads, advance, then drain the scoreboard.
   task automatic step();
      exp_t       e;
      logic [2:0] act_e;
      logic       conf_e;
      vm_n = vm;
      pm_n = pm;
      if (vpu_we)
         for (int k = 0; k < NL; k++)
            if (!vpu_masked || pm[vpu_pidx][k]) vm_n[vpu_widx][k*LW +: LW] = vpu_wdata[k*LW +: LW];
      if (mpu_we) vm_n[mpu_widx] = mpu_wdata;
      if (rpd_we) pm_n[rpd_widx] = rpd_wdata;
      if (!rst_n) begin
         vm_n = '{default: '0};
         pm_n = '{default: '0};
      end
      for (int b = 0; b < 2; b++) begin
         if (!rst_n) begin
            for (int s = 0; s < 5; s++) push(b, s, '0);
         end else begin
            if (mpu_re) push(b, 0, b ? vm_n[mpu_ridx] : vm[mpu_ridx]);
            if (rs_re) begin
               push(b, 1, b ? vm_n[rs0_idx] : vm[rs0_idx]);
               push(b, 2, b ? vm_n[rs1_idx] : vm[rs1_idx]);
            end
            if (rps_re) begin
               push(b, 3, {{(VW-PW){1'b0}}, b ? pm_n[rps0_idx] : pm[rps0_idx]});
               push(b, 4, {{(VW-PW){1'b0}}, b ? pm_n[rps1_idx] : pm[rps1_idx]});
            end
         end
      end
      act_e  = rst_n ? {rps_re, rs_re, mpu_re} : 3'b000;
      conf_e = rst_n && mpu_we && vpu_we && (mpu_widx == vpu_widx);
      @(posedge clk);
      #1;
      vm = vm_n;
      pm = pm_n;
      for (int b = 0; b < 2; b++) begin
         for (int s = 0; s < 3; s++)
            check($sformatf("act[%0d][%0d]", b, s), VW'(act_o[b][s]), VW'(act_e[s]));
         check($sformatf("conflict[%0d]", b), VW'(conf_o[b]), VW'(conf_e));
      end
      while (sb.size() > 0) begin
         e = sb.pop_front();
         check($sformatf("rdata inst%0d sel%0d", e.inst, e.sel), obs(e.inst, e.sel), e.d);
      end
   endtask

   logic [VW-1:0] v_a5, v_5a, v_11, v_22, v_low4, v_x, v_y;

   initial begin
      v_a5   = {NL{32'hA5A5_A5A5}};
      v_5a   = {NL{32'h5A5A_5A5A}};
      v_11   = {NL{32'h1111_1111}};
      v_22   = {NL{32'h2222_2222}};
      v_low4 = {{(VW-4*LW){1'b0}}, {(4*LW){1'b1}}};
      v_x    = rnd_vec();
      v_y    = rnd_vec();
      vm = '{default: '0};
      pm = '{default: '0};
      idle();
      mpu_widx = 0; mpu_ridx = 0; vpu_widx = 0; rs0_idx = 0; rs1_idx = 0;
      vpu_pidx = 0; rpd_widx = 0; rps0_idx = 0; rps1_idx = 0;
      mpu_wdata = '0; vpu_wdata = '0; rpd_wdata = '0;

      // Reset, with a stray request that must be ignored
      rst_n = 0;
      mpu_re = 1;
      step();
      idle();
      step();
      rst_n = 1;

      // Read every entry after reset
      for (int i = 0; i < 16; i++) begin
         mpu_re = 1; mpu_ridx = 4'(i);
         rs_re = 1; rs0_idx = 4'(i); rs1_idx = 4'(15 - i);
         rps_re = 1; rps0_idx = 3'(i); rps1_idx = 3'(7 - (i % 8));
         step();
      end
      idle();
      step();

      // Independent writes on both ports
      mpu_we = 1; mpu_widx = 3; mpu_wdata = v_a5;
      vpu_we = 1; vpu_widx = 7; vpu_wdata = v_5a;
      step();
      idle();
      rs_re = 1; rs0_idx = 3; rs1_idx = 7;
      step();
      check("v3_value", vdata[1][1], v_a5);
      check("v7_value", vdata[0][2], v_5a);
      idle();
      step();
      check("rs_hold", vdata[1][2], v_5a);

      // Same-index collision: mpu wins
      mpu_we = 1; mpu_widx = 5; mpu_wdata = v_11;
      vpu_we = 1; vpu_widx = 5; vpu_wdata = v_22;
      step();
      check("conflict_pulse", VW'(conf_o[1]), VW'(1));
      idle();
      mpu_re = 1; mpu_ridx = 5;
      step();
      check("conflict_clear", VW'(conf_o[0]), VW'(0));
      check("v5_mpu_wins", vdata[0][0], v_11);

      // Predicated write through p2
      idle();
      rpd_we = 1; rpd_widx = 2; rpd_wdata = 64'hF;
      step();
      idle();
      vpu_we = 1; vpu_widx = 1; vpu_wdata = '1; vpu_masked = 1; vpu_pidx = 2;
      step();
      idle();
      rs_re = 1; rs0_idx = 1; rs1_idx = 1;
      step();
      check("v1_masked", vdata[1][1], v_low4);
      idle();
      rpd_we = 1; rpd_widx = 2; rpd_wdata = '0;
      step();
      idle();
      vpu_we = 1; vpu_widx = 1; vpu_wdata = '1; vpu_masked = 1; vpu_pidx = 2;
      step();
      idle();
      rs_re = 1; rs0_idx = 1; rs1_idx = 4;
      step();
      check("v1_zero_mask", vdata[0][1], v_low4);

      // Mask from old predicate while the same predicate is rewritten this edge
      idle();
      rpd_we = 1; rpd_widx = 2; rpd_wdata = '1;
      vpu_we = 1; vpu_widx = 2; vpu_wdata = v_5a; vpu_masked = 1; vpu_pidx = 2;
      step();
      idle();
      mpu_re = 1; mpu_ridx = 2;
      step();
      check("mask_no_bypass", vdata[1][0], '0);

      // Masked vpu write colliding with mpu write
      idle();
      mpu_we = 1; mpu_widx = 1; mpu_wdata = v_22;
      vpu_we = 1; vpu_widx = 1; vpu_wdata = v_11; vpu_masked = 1; vpu_pidx = 2;
      step();
      idle();
      mpu_re = 1; mpu_ridx = 1;
      step();
      check("masked_conflict", vdata[1][0], v_22);

      // Same-edge write and read: bypass vs read-first
      idle();
      mpu_we = 1; mpu_widx = 9; mpu_wdata = v_y;
      step();
      idle();
      vpu_we = 1; vpu_widx = 9; vpu_wdata = v_x;
      mpu_re = 1; mpu_ridx = 9;
      rpd_we = 1; rpd_widx = 4; rpd_wdata = 64'hDEAD_BEEF_0123_4567;
      rps_re = 1; rps0_idx = 4; rps1_idx = 4;
      step();
      check("bypass_v9", vdata[1][0], v_x);
      check("readfirst_v9", vdata[0][0], v_y);
      check("bypass_p4", VW'(pdata[1][1]), VW'(64'hDEAD_BEEF_0123_4567));
      check("readfirst_p4", VW'(pdata[0][0]), '0);
      idle();
      mpu_re = 1; mpu_ridx = 9;
      rps_re = 1;
      step();
      check("later_v9", vdata[0][0], v_x);

      // Random traffic over a narrow index range to provoke collisions
      for (int n = 0; n < 300; n++) begin
         mpu_we = 1'($urandom); mpu_widx = 4'($urandom_range(0, 3)); mpu_wdata = rnd_vec();
         vpu_we = 1'($urandom); vpu_widx = 4'($urandom_range(0, 3)); vpu_wdata = rnd_vec();
         vpu_masked = 1'($urandom); vpu_pidx = 3'($urandom_range(0, 1));
         rpd_we = 1'($urandom); rpd_widx = 3'($urandom_range(0, 1));
         rpd_wdata = {$urandom, $urandom};
         mpu_re = 1'($urandom); mpu_ridx = 4'($urandom_range(0, 3));
         rs_re = 1'($urandom); rs0_idx = 4'($urandom_range(0, 3)); rs1_idx = 4'($urandom_range(0, 3));
         rps_re = 1'($urandom); rps0_idx = 3'($urandom_range(0, 1)); rps1_idx = 3'($urandom_range(0, 1));
         step();
      end

      // Reset in the middle of back-to-back reads
      idle();
      mpu_re = 1; mpu_ridx = 3; rs_re = 1; rs0_idx = 9; rs1_idx = 0; rps_re = 1;
      step();
      step();
      rst_n = 0;
      step();
      check("rst_act", VW'(act_o[1][1]), VW'(0));
      rst_n = 1;
      idle();
      step();
      for (int i = 0; i < 16; i++) begin
         mpu_re = 1; mpu_ridx = 4'(i);
         rs_re = 1; rs0_idx = 4'(i); rs1_idx = 4'(i);
         rps_re = 1; rps0_idx = 3'(i); rps1_idx = 3'(i);
         step();
         check($sformatf("post_rst_v%0d", i), vdata[1][0], '0);
      end
      idle();
      step();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
